// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle.
// Carries the hazard/forwarding observations coming out of the datapath and
// the sequencing controls going back into it, plus the halt handshake and
// the two performance counters.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Observations from the pipeline registers
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             idex_mread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             exmem_rw;
    logic [REG_W-1:0] exmem_rd;
    logic             memwb_rw;
    logic [REG_W-1:0] memwb_rd;
    logic             mem_branch;
    logic             mem_zf;
    logic             halt_req;

    // Controls back to the pipeline
    logic             pc_write;
    logic             pc_src;
    logic             if_id_write;
    logic             flush_if_id;
    logic             id_ex_bubble;
    logic             flush_ex_mem;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath / external agent side
    modport master (
        output id_rs, id_rt, idex_mread, idex_rt, ex_rs, ex_rt,
               exmem_rw, exmem_rd, memwb_rw, memwb_rd,
               mem_branch, mem_zf, halt_req,
        input  pc_write, pc_src, if_id_write, flush_if_id, id_ex_bubble,
               flush_ex_mem, fwd_a, fwd_b, halt_ack, stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_rs, id_rt, idex_mread, idex_rt, ex_rs, ex_rt,
               exmem_rw, exmem_rd, memwb_rw, memwb_rd,
               mem_branch, mem_zf, halt_req,
        output pc_write, pc_src, if_id_write, flush_if_id, id_ex_bubble,
               flush_ex_mem, fwd_a, fwd_b, halt_ack, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing controller.
// Detects load-use hazards, flushes wrong-path work on a taken branch in MEM,
// selects ALU forwarding sources, and drains/holds the pipeline on request
// from an external agent. Stall cycles and flushes are counted with
// saturating counters.
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic         CLK,
    input  logic         RSTn,
    hazard_ctrl_if.slave hz
);

    localparam int               DW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             halt_ack_q, halt_ack_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic take;
    logic lu;
    logic stall_inc;
    logic flush_inc;

    // Hazard terms: branch resolved taken in MEM, and a load in EX feeding the instruction in ID
    always_comb begin
        take = hz.mem_branch & hz.mem_zf;
        lu   = hz.idex_mread & (hz.idex_rt != REG_ZERO) &
               ((hz.idex_rt == hz.id_rs) | (hz.idex_rt == hz.id_rt));
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; register 0 is never forwarded
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (hz.exmem_rw && (hz.exmem_rd != REG_ZERO) && (hz.exmem_rd == hz.ex_rs)) begin
            hz.fwd_a = 2'b10;
        end else if (hz.memwb_rw && (hz.memwb_rd != REG_ZERO) && (hz.memwb_rd == hz.ex_rs)) begin
            hz.fwd_a = 2'b01;
        end
        if (hz.exmem_rw && (hz.exmem_rd != REG_ZERO) && (hz.exmem_rd == hz.ex_rt)) begin
            hz.fwd_b = 2'b10;
        end else if (hz.memwb_rw && (hz.memwb_rd != REG_ZERO) && (hz.memwb_rd == hz.ex_rt)) begin
            hz.fwd_b = 2'b01;
        end
    end

    // Next state and Mealy sequencing controls; a taken branch overrides everything else
    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.pc_src       = 1'b0;
        hz.flush_if_id  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.flush_ex_mem = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (take) begin
                    hz.pc_src       = 1'b1;
                    hz.flush_if_id  = 1'b1;
                    hz.id_ex_bubble = 1'b1;
                    hz.flush_ex_mem = 1'b1;
                    flush_inc       = 1'b1;
                end else begin
                    if (lu) begin
                        hz.pc_write     = 1'b0;
                        hz.if_id_write  = 1'b0;
                        hz.id_ex_bubble = 1'b1;
                        stall_inc       = 1'b1;
                    end
                    if (hz.halt_req) begin
                        hz.pc_write     = 1'b0;
                        hz.if_id_write  = 1'b0;
                        hz.id_ex_bubble = 1'b1;
                        state_d         = DRAIN;
                        drain_cnt_d     = '0;
                    end
                end
            end

            DRAIN: begin
                if (take) begin
                    hz.pc_src       = 1'b1;
                    hz.flush_if_id  = 1'b1;
                    hz.id_ex_bubble = 1'b1;
                    hz.flush_ex_mem = 1'b1;
                    flush_inc       = 1'b1;
                    drain_cnt_d     = '0;
                    if (!hz.halt_req) begin
                        state_d = RUN;
                    end
                end else begin
                    hz.pc_write     = 1'b0;
                    hz.if_id_write  = 1'b0;
                    hz.id_ex_bubble = 1'b1;
                    if (!hz.halt_req) begin
                        state_d     = RUN;
                        drain_cnt_d = '0;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end

            HALTED: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
                if (!hz.halt_req) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d     = RUN;
                drain_cnt_d = '0;
            end
        endcase

        halt_ack_d = (state_d == HALTED);
    end

    // State, drain counter and registered halt acknowledge
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            halt_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_ack_q  <= halt_ack_d;
        end
    end

    // Saturating performance counters for load-use stalls and taken-branch flushes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.halt_ack  = halt_ack_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change just after a rising edge; combinational outputs are checked
// a moment later and registered outputs after the following edge.
module tb_hazard_ctrl;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz ();

    hazard_ctrl #(
        .REG_W    (5),
        .CNT_W    (16),
        .DRAIN_CYC(3)
    ) dut (
        .CLK (clk),
        .RSTn(rstN),
        .hz  (hz)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic pcw, input logic src, input logic ifw,
                             input logic fif, input logic bub, input logic fem);
        checkOutput({tag, ".pc_write"},     32'(hz.pc_write),     32'(pcw));
        checkOutput({tag, ".pc_src"},       32'(hz.pc_src),       32'(src));
        checkOutput({tag, ".if_id_write"},  32'(hz.if_id_write),  32'(ifw));
        checkOutput({tag, ".flush_if_id"},  32'(hz.flush_if_id),  32'(fif));
        checkOutput({tag, ".id_ex_bubble"}, 32'(hz.id_ex_bubble), 32'(bub));
        checkOutput({tag, ".flush_ex_mem"}, 32'(hz.flush_ex_mem), 32'(fem));
    endtask

    task automatic applyStimulus(input logic mread, input logic [4:0] idexRt, input logic [4:0] idRs,
                                 input logic [4:0] idRt, input logic branch, input logic zf,
                                 input logic haltReq);
        hz.idex_mread = mread;
        hz.idex_rt    = idexRt;
        hz.id_rs      = idRs;
        hz.id_rt      = idRt;
        hz.mem_branch = branch;
        hz.mem_zf     = zf;
        hz.halt_req   = haltReq;
    endtask

    task automatic applyFwd(input logic exRw, input logic [4:0] exRd, input logic wbRw,
                            input logic [4:0] wbRd, input logic [4:0] exRs, input logic [4:0] exRt);
        hz.exmem_rw = exRw;
        hz.exmem_rd = exRd;
        hz.memwb_rw = wbRw;
        hz.memwb_rd = wbRd;
        hz.ex_rs    = exRs;
        hz.ex_rt    = exRt;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        applyFwd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Reset state
        #12;
        checkOutput("rst.halt_ack",  32'(hz.halt_ack),  32'd0);
        checkOutput("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        checkOutput("rst.flush_cnt", 32'(hz.flush_cnt), 32'd0);
        checkCtrl("rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.fwd_a", 32'(hz.fwd_a), 32'd0);
        rstN = 1'b1;
        nextCycle();

        // Forwarding priority and register-0 suppression
        applyFwd(1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5);
        #1;
        checkOutput("fwd1.a", 32'(hz.fwd_a), 32'd2);
        checkOutput("fwd1.b", 32'(hz.fwd_b), 32'd2);
        applyFwd(1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd5);
        #1;
        checkOutput("fwd2.a", 32'(hz.fwd_a), 32'd1);
        checkOutput("fwd2.b", 32'(hz.fwd_b), 32'd1);
        applyFwd(1'b1, 5'd6, 1'b1, 5'd5, 5'd5, 5'd6);
        #1;
        checkOutput("fwd3.a", 32'(hz.fwd_a), 32'd1);
        checkOutput("fwd3.b", 32'(hz.fwd_b), 32'd2);
        applyFwd(1'b0, 5'd5, 1'b1, 5'd0, 5'd5, 5'd0);
        #1;
        checkOutput("fwd4.a", 32'(hz.fwd_a), 32'd0);
        checkOutput("fwd4.b", 32'(hz.fwd_b), 32'd0);
        applyFwd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Load-use on rt: one stall cycle
        nextCycle();
        applyStimulus(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0);
        #1;
        checkCtrl("lu1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu1.stall_cnt", 32'(hz.stall_cnt), 32'd1);
        checkCtrl("lu1.after", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load into register 0 never stalls
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkCtrl("lu0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("lu0.stall_cnt", 32'(hz.stall_cnt), 32'd1);

        // Load-use on rs
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
        #1;
        checkCtrl("lu2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu2.stall_cnt", 32'(hz.stall_cnt), 32'd2);

        // Taken branch beats a simultaneous load-use
        applyStimulus(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        #1;
        checkCtrl("br1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br1.stall_cnt", 32'(hz.stall_cnt), 32'd2);
        checkOutput("br1.flush_cnt", 32'(hz.flush_cnt), 32'd1);

        // Branch not taken: no flush
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkCtrl("br0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("br0.flush_cnt", 32'(hz.flush_cnt), 32'd1);

        // Halt: entry cycle plus three drain cycles held, then acknowledge
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checkCtrl("halt.entry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkCtrl($sformatf("halt.drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("halt.drain%0d.ack", i), 32'(hz.halt_ack), 32'd0);
        end
        nextCycle();
        checkOutput("halt.ack", 32'(hz.halt_ack), 32'd1);
        checkCtrl("halt.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Load-use and branch while halted change nothing
        applyStimulus(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1);
        #1;
        checkCtrl("halt.ignore", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("halt.ignore.stall", 32'(hz.stall_cnt), 32'd2);
        checkOutput("halt.ignore.flush", 32'(hz.flush_cnt), 32'd1);
        checkOutput("halt.ignore.ack",   32'(hz.halt_ack),  32'd1);

        // Release: held this cycle, running after the edge
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("release.pc_write", 32'(hz.pc_write), 32'd0);
        nextCycle();
        checkOutput("release.ack",      32'(hz.halt_ack), 32'd0);
        checkOutput("release.pc_write2", 32'(hz.pc_write), 32'd1);

        // Abort: halt request dropped after one cycle
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("abort.hold", 32'(hz.pc_write), 32'd0);
        checkOutput("abort.ack0", 32'(hz.halt_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("abort.run%0d.pcw", i), 32'(hz.pc_write), 32'd1);
            checkOutput($sformatf("abort.run%0d.ack", i), 32'(hz.halt_ack), 32'd0);
        end

        // Stall counter saturation
        applyStimulus(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            nextCycle();
        end
        checkOutput("sat.stall", 32'(hz.stall_cnt), 32'h0000_FFFF);
        nextCycle();
        checkOutput("sat.hold",  32'(hz.stall_cnt), 32'h0000_FFFF);
        checkOutput("sat.flush", 32'(hz.flush_cnt), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Taken branch in the second drain cycle restarts the drain
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        #1;
        checkCtrl("dbr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("dbr.flush_cnt", 32'(hz.flush_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("dbr.wait%0d.ack", i), 32'(hz.halt_ack), 32'd0);
            checkOutput($sformatf("dbr.wait%0d.bub", i), 32'(hz.id_ex_bubble), 32'd1);
            nextCycle();
        end
        checkOutput("dbr.ack", 32'(hz.halt_ack), 32'd1);

        // Asynchronous reset while halted
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("areset.ack",   32'(hz.halt_ack),  32'd0);
        checkOutput("areset.stall", 32'(hz.stall_cnt), 32'd0);
        checkOutput("areset.flush", 32'(hz.flush_cnt), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkCtrl("areset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;
        nextCycle();
        checkOutput("areset.run.ack", 32'(hz.halt_ack), 32'd0);
        checkOutput("areset.run.pcw", 32'(hz.pc_write), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage IF/ID/EX/MEM/WB datapath. It detects load-use hazards and stalls the front end. It flushes wrong-path instructions on a branch taken in MEM and generates ALU operand forwarding selects. It also runs a halt/drain handshake that empties the pipeline for an external agent such as a debugger or testbench. Two saturating performance counters record stall cycles and flushes.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, performance counter width
DRAIN_CYC, 3, cycles needed to retire the EX, MEM and WB occupants

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
id_rs  in  REG_W  rs field of the instruction in IF/ID
id_rt  in  REG_W  rt field of the instruction in IF/ID
idex_mread  in  1  MemRead of the instruction in ID/EX
idex_rt  in  REG_W  rt of the instruction in ID/EX
ex_rs  in  REG_W  rs of the instruction in EX
ex_rt  in  REG_W  rt of the instruction in EX
exmem_rw  in  1  RegWrite of the EX/MEM occupant
exmem_rd  in  REG_W  destination of the EX/MEM occupant
memwb_rw  in  1  RegWrite of the MEM/WB occupant
memwb_rd  in  REG_W  destination of the MEM/WB occupant
mem_branch  in  1  Branch control bit in MEM
mem_zf  in  1  registered ALU zero flag in MEM
halt_req  in  1  level request to drain and hold the pipeline
pc_write  out  1  PC load enable
pc_src  out  1  1 = PC loads the branch target
if_id_write  out  1  IF/ID load enable
flush_if_id  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  zero the ID/EX control fields
flush_ex_mem  out  1  zero the EX/MEM control fields
fwd_a  out  2  ALU A select: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
fwd_b  out  2  ALU B select, same encoding as fwd_a
halt_ack  out  1  pipeline empty and held (registered)
stall_cnt  out  CNT_W  load-use stall cycles counted
flush_cnt  out  CNT_W  taken branches counted

Behaviour:
- Reset (RSTn=0, async):
  - state=RUN, drain_cnt=0, halt_ack=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs take their RUN values.
- Forwarding (combinational, independent of state):
  - fwd_a=10 if exmem_rw and exmem_rd!=0 and exmem_rd==ex_rs.
  - Otherwise fwd_a=01 if memwb_rw and memwb_rd!=0 and memwb_rd==ex_rs.
  - Otherwise fwd_a=00.
  - EX/MEM has priority over MEM/WB. fwd_b is identical, using ex_rt.
- Derived terms:
  - take = mem_branch & mem_zf
  - lu = idex_mread & idex_rt!=0 & (idex_rt==id_rs | idex_rt==id_rt)
- Control outputs are Mealy. Priority is take > lu > halt.
- Default (RUN, no event): pc_write=1, if_id_write=1, pc_src=0, all flush/bubble outputs=0.
- take, in any state:
  - pc_src=1, pc_write=1, flush_if_id=1, id_ex_bubble=1, flush_ex_mem=1.
  - flush_cnt increments.
  - In DRAIN, drain_cnt reloads to 0.
  - In HALTED, take cannot occur because the pipeline is empty; ignore it.
- lu in RUN with no take:
  - pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly the cycles lu holds (normally 1).
  - stall_cnt increments each such cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FSM:
  - RUN: halt_req=1 and no take → DRAIN with drain_cnt=0. Entry-cycle outputs already use DRAIN values.
  - DRAIN:
    - Outputs: pc_write=0, if_id_write=0 (the IF/ID instruction is held, not flushed), id_ex_bubble=1.
    - drain_cnt increments each cycle. At drain_cnt==DRAIN_CYC-1 → HALTED and halt_ack=1 on that edge.
    - halt_req falling during DRAIN → RUN next cycle; no instruction is lost.
  - HALTED:
    - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, halt_ack=1.
    - halt_req=0 → RUN; halt_ack clears on the same edge.
- lu during DRAIN/HALTED produces no extra action (front end already held) and is not counted.
- RSTn asserted mid-DRAIN or mid-HALTED returns immediately to RUN with halt_ack=0.

Test Plan:
- Forwarding: exmem_rw=1, exmem_rd=5, memwb_rw=1, memwb_rd=5, ex_rs=5, ex_rt=5 → fwd_a=fwd_b=10. Then exmem_rd=0 → fwd_a=fwd_b=01.
- Load-use: idex_mread=1, idex_rt=8, id_rt=8 for one cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; stall_cnt 0→1. Same with idex_rt=0 → no stall.
- Branch: mem_branch=1, mem_zf=1 while lu=1 → pc_src=1, pc_write=1, all three flushes=1, stall_cnt unchanged, flush_cnt +1.
- Halt: halt_req=1 from RUN → 3 cycles of id_ex_bubble=1 with pc_write=0, then halt_ack=1. halt_req=0 → halt_ack=0 next edge, pc_write=1.
- Abort and branch in drain: halt_req high 1 cycle → RUN next cycle, halt_ack never 1. Separately, take in the 2nd DRAIN cycle → flush outputs asserted, halt_ack delayed to 3 cycles after the branch.
- Saturation/reset: force 65 536 stall cycles → stall_cnt=0xFFFF and holds. Pulse RSTn=0 in HALTED → all counters 0, halt_ack=0 asynchronously.
